// File: rtl/pipe_proc_hz.sv
// pipe_proc_hz: 5-stage (IF/ID/EX/ME/WB) pipelined core for the MIPS-subset ISA.
// Branches resolve in ID with one delay slot. EX operands are forwarded from ME and WB.
// Load-use and branch-operand hazards are handled by hardware interlocks.
// The register file is write-first. HALT freezes the core until w_rst.
// Optional feature macro: PROC_STATS_EN enables the r_cycles / r_stalls counters.
// When the macro is undefined, both outputs are tied to zero.
module pipe_proc_hz #(
   parameter int unsigned IMEM_AW   = 12,
   parameter int unsigned DMEM_AW   = 12,
   parameter int unsigned PROBE_REG = 30
) (
   input  logic        w_clk,
   input  logic        w_rst,
   output logic [31:0] r_rout,
   output logic        r_halt,
   output logic        r_retire,
   output logic [31:0] r_cycles,
   output logic [31:0] r_stalls
);

   localparam int unsigned PC_W      = IMEM_AW + 2;
   localparam logic [5:0]  OP_RTYPE  = 6'h00;
   localparam logic [5:0]  OP_ADDI   = 6'h08;
   localparam logic [5:0]  OP_LW     = 6'h23;
   localparam logic [5:0]  OP_SW     = 6'h2b;
   localparam logic [5:0]  OP_BEQ    = 6'h04;
   localparam logic [5:0]  OP_BNE    = 6'h05;
   localparam logic [5:0]  OP_HALT   = 6'h11;
   localparam logic [5:0]  FN_ADD    = 6'h20;
   localparam logic [4:0]  PROBE_IDX = 5'(PROBE_REG);

   // Storage (not cleared by reset)
   logic [31:0] imem [0:(2**IMEM_AW)-1];
   logic [31:0] dmem [0:(2**DMEM_AW)-1];
   logic [31:0] rf   [0:31];

   // IF / ID
   logic [PC_W-1:0] pc_q;
   logic            ifid_valid_q;
   logic [PC_W-1:0] ifid_pc4_q;
   logic [31:0]     ifid_ir_q;

   // ID / EX
   logic            idex_valid_q;
   logic            idex_add_q;
   logic            idex_lw_q;
   logic            idex_sw_q;
   logic            idex_halt_q;
   logic            idex_wr_q;
   logic [4:0]      idex_dst_q;
   logic [4:0]      idex_rs_q;
   logic [4:0]      idex_rt_q;
   logic [31:0]     idex_a_q;
   logic [31:0]     idex_b_q;
   logic [31:0]     idex_imm_q;

   // EX / ME
   logic            exme_valid_q;
   logic            exme_lw_q;
   logic            exme_sw_q;
   logic            exme_halt_q;
   logic            exme_wr_q;
   logic [4:0]      exme_dst_q;
   logic [31:0]     exme_alu_q;
   logic [31:0]     exme_sdata_q;

   // ME / WB
   logic            mewb_valid_q;
   logic            mewb_lw_q;
   logic            mewb_halt_q;
   logic            mewb_wr_q;
   logic [4:0]      mewb_dst_q;
   logic [31:0]     mewb_alu_q;
   logic [31:0]     mewb_rdata_q;

   // ID decode
   logic [5:0]  id_op;
   logic [5:0]  id_fn;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [31:0] id_simm;
   logic        id_add;
   logic        id_addi;
   logic        id_lw;
   logic        id_sw;
   logic        id_beq;
   logic        id_bne;
   logic        id_halt;
   logic        id_use_rs;
   logic        id_use_rt;
   logic        id_br;
   logic [4:0]  id_dst;
   logic        id_wr;
   logic [31:0] id_rs_val;
   logic [31:0] id_rt_val;

   // Hazard / control
   logic            wb_we;
   logic [31:0]     wb_val;
   logic            exme_fwd;
   logic            stall_lu;
   logic            stall_bex;
   logic            stall_bme;
   logic            stall;
   logic            freeze;
   logic            br_take;
   logic [31:0]     br_off;
   logic [PC_W-1:0] br_target;
   logic [PC_W-1:0] pc_plus4;

   // EX datapath
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [31:0] ex_alu;

   logic [DMEM_AW-1:0] exme_addr;

   assign id_op   = ifid_ir_q[31:26];
   assign id_rs   = ifid_ir_q[25:21];
   assign id_rt   = ifid_ir_q[20:16];
   assign id_rd   = ifid_ir_q[15:11];
   assign id_fn   = ifid_ir_q[5:0];
   assign id_simm = {{16{ifid_ir_q[15]}}, ifid_ir_q[15:0]};

   // Decode the ID instruction; bubbles decode to nothing, unknown opcodes to NOP.
   always_comb begin
      id_add  = 1'b0;
      id_addi = 1'b0;
      id_lw   = 1'b0;
      id_sw   = 1'b0;
      id_beq  = 1'b0;
      id_bne  = 1'b0;
      id_halt = 1'b0;
      if (ifid_valid_q) begin
         case (id_op)
            OP_RTYPE: id_add  = (id_fn == FN_ADD);
            OP_ADDI:  id_addi = 1'b1;
            OP_LW:    id_lw   = 1'b1;
            OP_SW:    id_sw   = 1'b1;
            OP_BEQ:   id_beq  = 1'b1;
            OP_BNE:   id_bne  = 1'b1;
            OP_HALT:  id_halt = 1'b1;
            default:  ;
         endcase
      end
   end

   assign id_br     = id_beq | id_bne;
   assign id_use_rs = id_add | id_addi | id_lw | id_sw | id_br;
   assign id_use_rt = id_add | id_sw | id_br;
   assign id_dst    = id_add ? id_rd : id_rt;
   assign id_wr     = (id_add | id_addi | id_lw) & (id_dst != 5'd0);

   // Writeback value and forwarding qualifiers
   assign wb_val   = mewb_lw_q ? mewb_rdata_q : mewb_alu_q;
   assign wb_we    = mewb_valid_q & mewb_wr_q;
   assign exme_fwd = exme_valid_q & exme_wr_q & ~exme_lw_q;

   // ID operand read: write-first register file, then ME forwarding for branch compares.
   always_comb begin
      id_rs_val = rf[id_rs];
      id_rt_val = rf[id_rt];
      if (wb_we && (mewb_dst_q == id_rs)) id_rs_val = wb_val;
      if (wb_we && (mewb_dst_q == id_rt)) id_rt_val = wb_val;
      if (exme_fwd && (exme_dst_q == id_rs)) id_rs_val = exme_alu_q;
      if (exme_fwd && (exme_dst_q == id_rt)) id_rt_val = exme_alu_q;
      if (id_rs == 5'd0) id_rs_val = '0;
      if (id_rt == 5'd0) id_rt_val = '0;
   end

   // Interlocks: load-use, branch fed by EX, branch fed by a load in ME
   assign stall_lu  = idex_valid_q & idex_lw_q & idex_wr_q &
                      ((id_use_rs & (idex_dst_q == id_rs)) |
                       (id_use_rt & (idex_dst_q == id_rt)));
   assign stall_bex = id_br & idex_valid_q & idex_wr_q &
                      ((idex_dst_q == id_rs) | (idex_dst_q == id_rt));
   assign stall_bme = id_br & exme_valid_q & exme_lw_q & exme_wr_q &
                      ((exme_dst_q == id_rs) | (exme_dst_q == id_rt));
   assign stall     = stall_lu | stall_bex | stall_bme;

   // HALT in WB freezes the core on the same edge that sets r_halt.
   assign freeze = r_halt | (mewb_valid_q & mewb_halt_q);

   // A stalled branch is not resolved; it is re-evaluated once operands are ready.
   assign br_take   = ~stall & ((id_beq & (id_rs_val == id_rt_val)) |
                                (id_bne & (id_rs_val != id_rt_val)));
   assign br_off    = {id_simm[29:0], 2'b00};
   assign br_target = ifid_pc4_q + br_off[PC_W-1:0];
   assign pc_plus4  = pc_q + PC_W'(4);

   // EX operand forwarding: ME (non-load) first, then WB, else the value latched in ID.
   always_comb begin
      ex_a = idex_a_q;
      ex_b = idex_b_q;
      if (exme_fwd && (exme_dst_q == idex_rs_q)) begin
         ex_a = exme_alu_q;
      end else if (wb_we && (mewb_dst_q == idex_rs_q)) begin
         ex_a = wb_val;
      end
      if (exme_fwd && (exme_dst_q == idex_rt_q)) begin
         ex_b = exme_alu_q;
      end else if (wb_we && (mewb_dst_q == idex_rt_q)) begin
         ex_b = wb_val;
      end
   end

   // ADD uses rt; ADDI, LW and SW use the sign-extended immediate.
   assign ex_alu    = ex_a + (idex_add_q ? ex_b : idex_imm_q);
   assign exme_addr = exme_alu_q[DMEM_AW+1:2];

   // Pipeline registers: PC/IfId hold on stall, a bubble enters EX, everything holds on freeze.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         pc_q         <= '0;
         ifid_valid_q <= 1'b0;
         idex_valid_q <= 1'b0;
         exme_valid_q <= 1'b0;
         mewb_valid_q <= 1'b0;
      end else if (!freeze) begin
         if (!stall) begin
            pc_q         <= br_take ? br_target : pc_plus4;
            ifid_valid_q <= 1'b1;
            ifid_pc4_q   <= pc_plus4;
         end
         idex_valid_q <= ifid_valid_q & ~stall;
         idex_add_q   <= id_add;
         idex_lw_q    <= id_lw;
         idex_sw_q    <= id_sw;
         idex_halt_q  <= id_halt;
         idex_wr_q    <= id_wr;
         idex_dst_q   <= id_dst;
         idex_rs_q    <= id_rs;
         idex_rt_q    <= id_rt;
         idex_a_q     <= id_rs_val;
         idex_b_q     <= id_rt_val;
         idex_imm_q   <= id_simm;

         exme_valid_q <= idex_valid_q;
         exme_lw_q    <= idex_lw_q;
         exme_sw_q    <= idex_sw_q;
         exme_halt_q  <= idex_halt_q;
         exme_wr_q    <= idex_wr_q;
         exme_dst_q   <= idex_dst_q;
         exme_alu_q   <= ex_alu;
         exme_sdata_q <= ex_b;

         mewb_valid_q <= exme_valid_q;
         mewb_lw_q    <= exme_lw_q;
         mewb_halt_q  <= exme_halt_q;
         mewb_wr_q    <= exme_wr_q;
         mewb_dst_q   <= exme_dst_q;
         mewb_alu_q   <= exme_alu_q;
      end
   end

   // Instruction memory: synchronous read into IR, held while ID is stalled.
   always_ff @(posedge w_clk) begin
      if (!freeze && !stall) begin
         ifid_ir_q <= imem[pc_q[IMEM_AW+1:2]];
      end
   end

   // Data memory: store and synchronous load read in ME; load data lands in MeWb.
   always_ff @(posedge w_clk) begin
      if (!w_rst && !freeze) begin
         if (exme_valid_q && exme_sw_q) begin
            dmem[exme_addr] <= exme_sdata_q;
         end
         mewb_rdata_q <= dmem[exme_addr];
      end
   end

   // Register file write in WB; $0 is never written since wr excludes index 0.
   always_ff @(posedge w_clk) begin
      if (!w_rst && !freeze && wb_we) begin
         rf[mewb_dst_q] <= wb_val;
      end
   end

   // Status outputs: probe mirror, sticky halt and retire strobe.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_rout   <= '0;
         r_halt   <= 1'b0;
         r_retire <= 1'b0;
      end else begin
         r_retire <= mewb_valid_q & ~r_halt;
         if (mewb_valid_q && mewb_halt_q) begin
            r_halt <= 1'b1;
         end
         if (!freeze && wb_we && (mewb_dst_q == PROBE_IDX)) begin
            r_rout <= wb_val;
         end
      end
   end

`ifdef PROC_STATS_EN
   logic [31:0] cycles_q;
   logic [31:0] stalls_q;

   // Cycle and interlock-bubble counters, stopped once halted.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         cycles_q <= '0;
         stalls_q <= '0;
      end else if (!r_halt) begin
         cycles_q <= cycles_q + 32'd1;
         if (stall && !freeze) begin
            stalls_q <= stalls_q + 32'd1;
         end
      end
   end

   assign r_cycles = cycles_q;
   assign r_stalls = stalls_q;
`else
   assign r_cycles = '0;
   assign r_stalls = '0;
`endif

   logic unused_bits;
   assign unused_bits = ^{ifid_ir_q[10:6], br_off[31:PC_W]};

endmodule

// File: tb/tb_pipe_proc_hz.sv
// Directed-vector bench for pipe_proc_hz: small programs are loaded into instruction memory.
// Each program is run to HALT after a reset. Cycle count, retire count, probe value and
// selected architectural state are then compared against hand-computed expectations.
module tb_pipe_proc_hz;

   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2b;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] HALT   = 32'h4400_0000;

   logic        w_clk;
   logic        w_rst;
   logic [31:0] r_rout;
   logic        r_halt;
   logic        r_retire;
   logic [31:0] r_cycles;
   logic [31:0] r_stalls;

   int n_cmp = 0;
   int n_err = 0;

   pipe_proc_hz dut (
      .w_clk    (w_clk),
      .w_rst    (w_rst),
      .r_rout   (r_rout),
      .r_halt   (r_halt),
      .r_retire (r_retire),
      .r_cycles (r_cycles),
      .r_stalls (r_stalls)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input int imm);
      logic [15:0] im;
      im = 16'(imm);
      return {op, rs, rt, im};
   endfunction

   function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt);
      return {6'h00, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) dut.imem[i] = NOP;
   endtask

   // Reset, run to HALT (bounded), drain, then check the run against expectations.
   task automatic run_prog(input string tag, input int exp_cyc, input int exp_ret,
                           input int exp_st, input logic [31:0] exp_rout);
      int cyc;
      int n_ret;
      int first_ret;
      w_rst = 1'b1;
      @(posedge w_clk);
      #1;
      w_rst = 1'b0;
      check_eq({tag, "_rst_pc"}, 32'(dut.pc_q), 32'd0);
      check_eq({tag, "_rst_halt"}, {31'd0, r_halt}, 32'd0);
      check_eq({tag, "_rst_rout"}, r_rout, 32'd0);
      check_eq({tag, "_rst_retire"}, {31'd0, r_retire}, 32'd0);
      check_eq({tag, "_rst_cycles"}, r_cycles, 32'd0);
      check_eq({tag, "_rst_stalls"}, r_stalls, 32'd0);
      cyc       = 0;
      n_ret     = 0;
      first_ret = -1;
      while (!r_halt && cyc < exp_cyc + 50) begin
         @(posedge w_clk);
         #1;
         cyc++;
         if (r_retire) begin
            n_ret++;
            if (first_ret < 0) first_ret = cyc;
         end
      end
      repeat (6) begin
         @(posedge w_clk);
         #1;
         if (r_retire) n_ret++;
      end
      check_eq({tag, "_cycles"}, cyc, exp_cyc);
      check_eq({tag, "_retires"}, n_ret, exp_ret);
      check_eq({tag, "_first_ret"}, first_ret, 32'd5);
      check_eq({tag, "_halt"}, {31'd0, r_halt}, 32'd1);
      check_eq({tag, "_rout"}, r_rout, exp_rout);
`ifdef PROC_STATS_EN
      check_eq({tag, "_stat_stalls"}, r_stalls, exp_st);
      check_eq({tag, "_stat_cycles"}, r_cycles, exp_cyc);
`else
      check_eq({tag, "_stat_stalls"}, r_stalls, 32'd0 & exp_st);
      check_eq({tag, "_stat_cycles"}, r_cycles, 32'd0);
`endif
   endtask

   task automatic load_regress();
      clear_imem();
      dut.imem[0]  = enc_i(OP_ADDI, 5'd0, 5'd1, 12000);
      dut.imem[1]  = enc_i(OP_SW,   5'd0, 5'd1, 64);
      dut.imem[2]  = enc_i(OP_ADDI, 5'd0, 5'd1, 12345);
      dut.imem[3]  = enc_i(OP_SW,   5'd0, 5'd1, 68);
      dut.imem[4]  = enc_i(OP_ADDI, 5'd0, 5'd1, 12000);
      dut.imem[5]  = enc_i(OP_SW,   5'd0, 5'd1, 72);
      dut.imem[6]  = enc_i(OP_ADDI, 5'd0, 5'd1, 12795);
      dut.imem[7]  = enc_i(OP_SW,   5'd0, 5'd1, 76);
      dut.imem[8]  = enc_i(OP_ADDI, 5'd0, 5'd2, 64);
      dut.imem[9]  = enc_i(OP_ADDI, 5'd0, 5'd3, 4);
      dut.imem[10] = enc_add(5'd30, 5'd0, 5'd0);
      dut.imem[11] = enc_i(OP_LW,   5'd2, 5'd5, 0);
      dut.imem[12] = enc_add(5'd30, 5'd30, 5'd5);
      dut.imem[13] = enc_i(OP_ADDI, 5'd3, 5'd3, -1);
      dut.imem[14] = enc_i(OP_BNE,  5'd3, 5'd0, -4);
      dut.imem[15] = enc_i(OP_ADDI, 5'd2, 5'd2, 4);
      dut.imem[16] = enc_i(OP_ADDI, 5'd0, 5'd6, 11);
      dut.imem[17] = enc_add(5'd30, 5'd30, 5'd30);
      dut.imem[18] = enc_i(OP_ADDI, 5'd6, 5'd6, -1);
      dut.imem[19] = enc_i(OP_BNE,  5'd6, 5'd0, -3);
      dut.imem[20] = NOP;
      dut.imem[21] = HALT;
      dut.imem[22] = enc_i(OP_SW,   5'd0, 5'd0, 64);
      dut.imem[23] = enc_i(OP_ADDI, 5'd0, 5'd30, 32'h77);
      dut.imem[24] = enc_i(OP_ADDI, 5'd0, 5'd30, 32'h55);
   endtask

   initial begin
      w_rst = 1'b1;
      repeat (2) @(posedge w_clk);

      // Forwarding chain without stalls
      clear_imem();
      dut.imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 5);
      dut.imem[1] = enc_add(5'd2, 5'd1, 5'd1);
      dut.imem[2] = enc_add(5'd30, 5'd2, 5'd1);
      dut.imem[3] = HALT;
      run_prog("fwd", 8, 4, 0, 32'd15);
      check_eq("fwd_r2", dut.rf[2], 32'd10);

      // Store, load, load-use stall
      clear_imem();
      dut.imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 7);
      dut.imem[1] = enc_i(OP_SW,   5'd0, 5'd1, 0);
      dut.imem[2] = enc_i(OP_LW,   5'd0, 5'd3, 0);
      dut.imem[3] = enc_add(5'd30, 5'd3, 5'd3);
      dut.imem[4] = HALT;
      run_prog("ldu", 10, 5, 1, 32'd14);
      check_eq("ldu_mem0", dut.dmem[0], 32'd7);

      // Countdown loop with BNE stalled on the preceding ADDI
      clear_imem();
      dut.imem[0] = enc_i(OP_ADDI, 5'd0, 5'd4, 3);
      dut.imem[1] = enc_i(OP_ADDI, 5'd4, 5'd4, -1);
      dut.imem[2] = enc_i(OP_BNE,  5'd4, 5'd0, -2);
      dut.imem[3] = NOP;
      dut.imem[4] = HALT;
      run_prog("loop", 18, 11, 3, 32'd0);
      check_eq("loop_r4", dut.rf[4], 32'd0);

      // LW feeding BEQ: two-cycle stall, taken, delay slot once, path skipped
      clear_imem();
      dut.imem[0] = enc_add(5'd7, 5'd0, 5'd0);
      dut.imem[1] = enc_i(OP_ADDI, 5'd0, 5'd6, 9);
      dut.imem[2] = enc_i(OP_SW,   5'd0, 5'd6, 16);
      dut.imem[3] = enc_i(OP_LW,   5'd0, 5'd5, 16);
      dut.imem[4] = enc_i(OP_BEQ,  5'd5, 5'd6, 2);
      dut.imem[5] = enc_i(OP_ADDI, 5'd7, 5'd7, 1);
      dut.imem[6] = enc_i(OP_ADDI, 5'd7, 5'd7, 100);
      dut.imem[7] = enc_add(5'd30, 5'd7, 5'd6);
      dut.imem[8] = HALT;
      run_prog("beq", 14, 8, 2, 32'd10);
      check_eq("beq_r7", dut.rf[7], 32'd1);

      // Sum/array regression then HALT; younger SW/ADDI must never take effect
      load_regress();
      run_prog("reg", 100, 77, 19, 32'h05ff_a000);
      check_eq("reg_r2", dut.rf[2], 32'd80);
      check_eq("reg_r30", dut.rf[30], 32'h05ff_a000);
      check_eq("reg_mem16", dut.dmem[16], 32'd12000);
      check_eq("reg_mem19", dut.dmem[19], 32'd12795);

      // Reset mid-loop, then re-run to the same result
      w_rst = 1'b1;
      @(posedge w_clk);
      #1;
      w_rst = 1'b0;
      repeat (40) @(posedge w_clk);
      #1;
      check_eq("mid_running", {31'd0, r_halt}, 32'd0);
      run_prog("rerun", 100, 77, 19, 32'h05ff_a000);
      check_eq("rerun_mem16", dut.dmem[16], 32'd12000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
